bsg_fsb_murn_uplink: RTL and testbench

BSG_FSB_MURN_UPLINK -- requirements
Module: bsg_fsb_murn_uplink

---
 rtl/bsg_fsb_murn_pkg.sv | 30 +++
 rtl/bsg_fsb_murn_two_fifo.sv | 70 +++++++
 rtl/bsg_fsb_murn_uplink.sv | 151 +++++++++++++++
 tb/tb_bsg_fsb_murn_uplink.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fsb_murn_pkg.sv
// ---------------------------------------------------------------------------
// bsg_fsb_murn_pkg
// Shared definitions for the FSB murn uplink:
//   - field-width constants of the default 16-bit FSB packet
//   - switch opcode enumeration carried in the low payload bits
//   - packed packet struct {id, switch flag, payload}
// ---------------------------------------------------------------------------
package bsg_fsb_murn_pkg;

    localparam int FSB_WIDTH     = 16;
    localparam int ID_WIDTH      = 5;
    localparam int PAYLOAD_WIDTH = FSB_WIDTH - ID_WIDTH - 1;
    localparam int OP_WIDTH      = 2;

    // Switch command opcodes, placed in payload[1:0] of a switch packet
    typedef enum logic [OP_WIDTH-1:0] {
        OP_ENABLE         = 2'b00,
        OP_DISABLE        = 2'b01,
        OP_RESET_ASSERT   = 2'b10,
        OP_RESET_DEASSERT = 2'b11
    } murn_op_e;

    // One FSB packet; the switch flag separates control from node data
    typedef struct packed {
        logic [ID_WIDTH-1:0]      id;
        logic                     sw;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } murn_pkt_s;

endpackage

// File: rtl/bsg_fsb_murn_two_fifo.sv
// ---------------------------------------------------------------------------
// bsg_fsb_murn_two_fifo
// Two-entry FIFO with valid/ready on both sides. Output data and valid come
// straight from registers. When full, an entry is still accepted in a cycle
// where the head leaves, so the FIFO sustains one packet per cycle.
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   v_i, data_i, ready_o enqueue side (transfer on v_i & ready_o)
//   v_o, data_o, ready_i dequeue side (transfer on v_o & ready_i)
// ---------------------------------------------------------------------------
module bsg_fsb_murn_two_fifo #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [width_p-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         cnt_q;
    logic [1:0]         cnt_d;
    logic               enq_s;
    logic               deq_s;

    // Handshake decode and occupancy next-state
    always_comb begin
        v_o     = (cnt_q != 2'd0);
        // When full, v_o is high, so ready_i alone means the head leaves now
        ready_o = (cnt_q != 2'd2) | ready_i;
        enq_s   = v_i & ready_o;
        deq_s   = v_o & ready_i;
        case ({enq_s, deq_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign data_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; reset empties the FIFO and zeroes data
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            // Full + enqueue + dequeue writes the slot being vacated, which
            // becomes the tail once the read pointer moves on: order holds
            if (enq_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bsg_fsb_murn_uplink.sv
// ---------------------------------------------------------------------------
// bsg_fsb_murn_uplink
// Merges one node's payload stream and a switch command stream into a single
// FSB packet stream through a two-entry output FIFO.
//   Packet: {id, switch flag, payload}
//     data   : {id_p,         1'b0, data_i}
//     switch : {cmd_dst_id_i, 1'b1, 0..0, cmd_op_i}
// Commands win arbitration, except that after cmd_burst_p consecutive
// accepted commands a pending data request gets the next slot.
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   node_en_i                   node enabled; low holds data off
//   v_i, data_i, ready_o        node payload handshake
//   cmd_v_i, cmd_op_i,
//   cmd_dst_id_i, cmd_ready_o   switch command handshake
//   v_o, data_o, ready_i        FSB packet output handshake
//   data_cnt_o, cmd_cnt_o       saturating transfer counts (only with
//                               BSG_FSB_MURN_UPLINK_STATS_EN defined)
// ---------------------------------------------------------------------------
module bsg_fsb_murn_uplink
    import bsg_fsb_murn_pkg::*;
#(
    parameter int width_p     = 16,
    parameter int id_width_p  = 5,
    parameter int id_p        = 5,
    parameter int cmd_burst_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          node_en_i,
    input  logic                          v_i,
    input  logic [width_p-id_width_p-2:0] data_i,
    output logic                          ready_o,
    input  logic                          cmd_v_i,
    input  logic [OP_WIDTH-1:0]           cmd_op_i,
    input  logic [id_width_p-1:0]         cmd_dst_id_i,
    output logic                          cmd_ready_o,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    input  logic                          ready_i
`ifdef BSG_FSB_MURN_UPLINK_STATS_EN
    ,
    output logic [15:0]                   data_cnt_o,
    output logic [15:0]                   cmd_cnt_o
`endif
);

    localparam int PAYLOAD_W = width_p - id_width_p - 1;
    localparam int BURST_W   = $clog2(cmd_burst_p + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(cmd_burst_p);
    localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

    logic               data_req_s;
    logic               data_win_s;
    logic               cmd_win_s;
    logic               data_acc_s;
    logic               cmd_acc_s;
    logic               fifo_ready_s;
    logic               enq_v_s;
    logic [width_p-1:0] data_pkt_s;
    logic [width_p-1:0] cmd_pkt_s;
    logic [width_p-1:0] enq_pkt_s;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;

    assign data_pkt_s = {id_width_p'(id_p), 1'b0, data_i};
    assign cmd_pkt_s  = {cmd_dst_id_i, 1'b1,
                         {(PAYLOAD_W-OP_WIDTH){1'b0}}, cmd_op_i};

    // Arbitration between node data and switch commands, enqueue selection
    always_comb begin
        data_req_s = v_i & node_en_i;
        data_win_s = data_req_s & (~cmd_v_i | (burst_q == BURST_MAX));
        cmd_win_s  = cmd_v_i & ~data_win_s;
        // Gating with reset_n_i keeps both readies low while reset is held
        data_acc_s = data_win_s & fifo_ready_s & reset_n_i;
        cmd_acc_s  = cmd_win_s & fifo_ready_s & reset_n_i;
        enq_v_s    = data_acc_s | cmd_acc_s;
        if (data_acc_s) begin
            enq_pkt_s = data_pkt_s;
        end else begin
            enq_pkt_s = cmd_pkt_s;
        end
    end

    assign ready_o     = data_acc_s;
    assign cmd_ready_o = cmd_acc_s;

    // Consecutive-command counter next-state
    always_comb begin
        // Starts over whenever data is taken or nobody on the data side waits
        if (data_acc_s | ~data_req_s) begin
            burst_d = '0;
        end else if (cmd_acc_s & (burst_q != BURST_MAX)) begin
            burst_d = burst_q + BURST_ONE;
        end else begin
            burst_d = burst_q;
        end
    end

    // Consecutive-command counter register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    bsg_fsb_murn_two_fifo #(
        .width_p (width_p)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (enq_v_s),
        .data_i    (enq_pkt_s),
        .ready_o   (fifo_ready_s),
        .v_o       (v_o),
        .data_o    (data_o),
        .ready_i   (ready_i)
    );

`ifdef BSG_FSB_MURN_UPLINK_STATS_EN
    logic [15:0] data_cnt_q;
    logic [15:0] cmd_cnt_q;
    logic        head_sw_s;
    logic        tx_s;

    assign head_sw_s = data_o[PAYLOAD_W];
    assign tx_s      = v_o & ready_i;

    // Saturating counts of packets leaving the FIFO, split by switch flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_cnt_q <= 16'd0;
            cmd_cnt_q  <= 16'd0;
        end else begin
            if (tx_s & ~head_sw_s & (data_cnt_q != 16'hFFFF)) begin
                data_cnt_q <= data_cnt_q + 16'd1;
            end
            if (tx_s & head_sw_s & (cmd_cnt_q != 16'hFFFF)) begin
                cmd_cnt_q <= cmd_cnt_q + 16'd1;
            end
        end
    end

    assign data_cnt_o = data_cnt_q;
    assign cmd_cnt_o  = cmd_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_fsb_murn_uplink.sv
// ---------------------------------------------------------------------------
// tb_bsg_fsb_murn_uplink
// Randomized and directed stimulus against a queue-based reference model of
// the uplink. Counters are checked too when BSG_FSB_MURN_UPLINK_STATS_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_bsg_fsb_murn_uplink;

    localparam int CMD_BURST = 4;
    localparam int NODE_ID   = 5;

    logic        clk;
    logic        reset_n;
    logic        node_en;
    logic        v_in;
    logic [9:0]  d_in;
    logic        ready_out;
    logic        cmd_v;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_dst;
    logic        cmd_ready;
    logic        v_out;
    logic [15:0] d_out;
    logic        ready_in;
`ifdef BSG_FSB_MURN_UPLINK_STATS_EN
    logic [15:0] data_cnt;
    logic [15:0] cmd_cnt;
`endif

    int          n_checks;
    int          n_errors;

    // Reference model state
    logic [15:0] exp_q[$];
    bit          flag_q[$];
    int          burst;
    int          tx_data;
    int          tx_cmd;

    // What the DUT showed at the last step's sampling point
    logic        seen_v;
    logic        seen_rd;
    logic        seen_crd;
    logic [15:0] seen_data;

    bsg_fsb_murn_uplink dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .node_en_i    (node_en),
        .v_i          (v_in),
        .data_i       (d_in),
        .ready_o      (ready_out),
        .cmd_v_i      (cmd_v),
        .cmd_op_i     (cmd_op),
        .cmd_dst_id_i (cmd_dst),
        .cmd_ready_o  (cmd_ready),
        .v_o          (v_out),
        .data_o       (d_out),
        .ready_i      (ready_in)
`ifdef BSG_FSB_MURN_UPLINK_STATS_EN
        ,
        .data_cnt_o   (data_cnt),
        .cmd_cnt_o    (cmd_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packet images computed straight from the field layout
    function automatic logic [15:0] data_pkt(input logic [9:0] d);
        return 16'(NODE_ID * 2048 + int'(d));
    endfunction

    function automatic logic [15:0] cmd_pkt(input logic [4:0] dst, input logic [1:0] op);
        return 16'(int'(dst) * 2048 + 1024 + int'(op));
    endfunction

    // One clock cycle: drive, check against the model, advance the model
    task automatic step(input logic v, input logic [9:0] d, input logic en,
                        input logic cv, input logic [1:0] op, input logic [4:0] dst,
                        input logic rdy);
        bit dreq, dwin, cwin, slot, e_rd, e_crd;
        logic [15:0] popped;
        @(negedge clk);
        v_in = v; d_in = d; node_en = en;
        cmd_v = cv; cmd_op = op; cmd_dst = dst; ready_in = rdy;
        #1;
        seen_v = v_out; seen_data = d_out; seen_rd = ready_out; seen_crd = cmd_ready;
        check_eq("v_o", v_out, (exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq("data_o", d_out, exp_q[0]);
`ifdef BSG_FSB_MURN_UPLINK_STATS_EN
        check_eq("data_cnt", data_cnt, tx_data);
        check_eq("cmd_cnt", cmd_cnt, tx_cmd);
`endif
        dreq  = v && en;
        dwin  = dreq && (!cv || burst >= CMD_BURST);
        cwin  = cv && !dwin;
        slot  = (exp_q.size() < 2) || rdy;
        e_rd  = dwin && slot;
        e_crd = cwin && slot;
        check_eq("ready_o", ready_out, e_rd);
        check_eq("cmd_ready_o", cmd_ready, e_crd);
        if (exp_q.size() != 0 && rdy) begin
            popped = exp_q.pop_front();
            flag_q.push_back(popped[10]);
            if (popped[10]) tx_cmd++;
            else            tx_data++;
        end
        if (e_rd)       exp_q.push_back(data_pkt(d));
        else if (e_crd) exp_q.push_back(cmd_pkt(dst, op));
        if (e_rd || !dreq)               burst = 0;
        else if (e_crd && burst < CMD_BURST) burst++;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 10'd0, 1'b1, 1'b0, 2'd0, 5'd0, rdy);
    endtask

    task automatic model_clear();
        exp_q.delete();
        flag_q.delete();
        burst = 0;
        tx_data = 0;
        tx_cmd = 0;
    endtask

    // Reset with busy inputs: outputs and readies must all sit at zero
    task automatic reset_dut();
        @(negedge clk);
        v_in = 1'b1; node_en = 1'b1; cmd_v = 1'b1; ready_in = 1'b1;
        reset_n = 1'b0;
        #1;
        check_eq("rst_v_o", v_out, 1'b0);
        check_eq("rst_data_o", d_out, 16'h0000);
        check_eq("rst_ready_o", ready_out, 1'b0);
        check_eq("rst_cmd_ready_o", cmd_ready, 1'b0);
`ifdef BSG_FSB_MURN_UPLINK_STATS_EN
        check_eq("rst_data_cnt", data_cnt, 16'd0);
        check_eq("rst_cmd_cnt", cmd_cnt, 16'd0);
`endif
        model_clear();
        @(negedge clk);
        v_in = 1'b0; cmd_v = 1'b0;
        reset_n = 1'b1;
    endtask

    bit fair_exp[10];
    int accepts;

    initial begin
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0; node_en = 1'b0; v_in = 1'b0; d_in = 10'd0;
        cmd_v = 1'b0; cmd_op = 2'd0; cmd_dst = 5'd0; ready_in = 1'b0;
        model_clear();
        fair_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        reset_dut();

        // Data packet format and one-cycle latency
        step(1'b1, 10'h155, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1);
        check_eq("dp_ready_o", seen_rd, 1'b1);
        idle(1'b1);
        check_eq("dp_v_o", seen_v, 1'b1);
        check_eq("dp_pkt", seen_data, 16'h2955);

        // Switch packet format
        step(1'b0, 10'd0, 1'b1, 1'b1, 2'b10, 5'd3, 1'b1);
        check_eq("sw_cmd_ready", seen_crd, 1'b1);
        idle(1'b1);
        check_eq("sw_pkt", seen_data, 16'h1C02);
        idle(1'b1);

        // Fairness: four commands then one data slot, repeating
        reset_dut();
        for (int i = 0; i < 11; i++)
            step(1'b1, 10'($urandom), 1'b1, 1'b1, 2'($urandom), 5'($urandom), 1'b1);
        check_eq("fair_count", flag_q.size(), 10);
        for (int i = 0; i < 10 && i < flag_q.size(); i++)
            check_eq($sformatf("fair_order%0d", i), flag_q[i], fair_exp[i]);

        // Backpressure: only two accepts while output is stalled
        reset_dut();
        accepts = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 10'($urandom), 1'b1, 1'b1, 2'($urandom), 5'($urandom), 1'b0);
            accepts += int'(seen_rd) + int'(seen_crd);
        end
        check_eq("bp_accepts", accepts, 2);
        check_eq("bp_ready_o", seen_rd, 1'b0);
        check_eq("bp_cmd_ready", seen_crd, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Node disabled: data held off, queue drains, commands still pass
        step(1'b0, 10'd0, 1'b1, 1'b1, 2'd1, 5'd7, 1'b0);
        step(1'b1, 10'h3AA, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1);
        check_eq("dis_ready_o", seen_rd, 1'b0);
        step(1'b1, 10'h3AA, 1'b0, 1'b1, 2'd3, 5'd9, 1'b1);
        check_eq("dis_ready_o2", seen_rd, 1'b0);
        check_eq("dis_cmd_ready", seen_crd, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset with a full FIFO clears the output immediately
        reset_dut();
        step(1'b0, 10'd0, 1'b1, 1'b1, 2'd2, 5'd1, 1'b0);
        step(1'b0, 10'd0, 1'b1, 1'b1, 2'd3, 5'd2, 1'b0);
        @(negedge clk);
        v_in = 1'b1; cmd_v = 1'b1; ready_in = 1'b0;
        #1;
        check_eq("full_v_o", v_out, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_v_o", v_out, 1'b0);
        check_eq("async_rst_data_o", d_out, 16'h0000);
        check_eq("async_rst_cmd_ready", cmd_ready, 1'b0);
        model_clear();
        @(negedge clk);
        v_in = 1'b0; cmd_v = 1'b0;
        reset_n = 1'b1;
        step(1'b0, 10'd0, 1'b1, 1'b1, 2'd0, 5'd4, 1'b1);
        check_eq("post_rst_accept", seen_crd, 1'b1);
        idle(1'b1);
        check_eq("post_rst_v_o", seen_v, 1'b1);
        check_eq("post_rst_pkt", seen_data, 16'h2400);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 1) != 0, 2'($urandom), 5'($urandom),
                 $urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
